// File: rtl/pc_next_predictor_if.sv
// pc_next_predictor_if
//   Fetch-stage <-> next-PC predictor bundle.
//   master : fetch stage (drives PC/instruction/redirect, consumes nextPC)
//   slave  : predictor   (consumes PC/instruction/redirect, drives nextPC)
//   PC          address being fetched this cycle (already redirect-muxed)
//   instruction word fetched at PC
//   nextPC      predicted next fetch address (combinational)
//   forcePC     previous fetch was mispredicted
//   forcePCdata correct target of the previous fetch
interface pc_next_predictor_if #(
  parameter int WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] PC;
  logic [WORD_SIZE-1:0] instruction;
  logic [WORD_SIZE-1:0] nextPC;
  logic                 forcePC;
  logic [WORD_SIZE-1:0] forcePCdata;

  modport master (
    output PC, instruction, forcePC, forcePCdata,
    input  nextPC
  );

  modport slave (
    input  PC, instruction, forcePC, forcePCdata,
    output nextPC
  );
endinterface

// File: rtl/pc_next_predictor.sv
// pc_next_predictor
//   Next-PC predictor for the 16-bit pipelined CPU fetch stage.
//   Predecodes JMP/JAL (opcode 9/10) in the fetched word; otherwise consults
//   a direct-mapped BTB trained by the pipeline's redirect, else PC+1.
//
//   Build option: define PCPRED_BTB_EN to build the BTB and last_pc
//   register. Undefined: no storage, redirect inputs ignored, nextPC is the
//   jump target or PC+1.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (clears valid bits and last_pc)
//   fif      pc_next_predictor_if.slave: PC, instruction, forcePC,
//            forcePCdata in; nextPC out
module pc_next_predictor #(
  parameter int WORD_SIZE      = 16,
  parameter int BTB_INDEX_BITS = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  pc_next_predictor_if.slave fif
);

  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;

  // ------------------------------------------------------------------
  // Predecode + sequential fallback (shared by both builds)
  // ------------------------------------------------------------------
  logic [3:0]           opcode;
  logic                 is_jump;
  logic [WORD_SIZE-1:0] jump_tgt;
  logic [WORD_SIZE-1:0] pc_inc;
  logic                 btb_hit;
  logic [WORD_SIZE-1:0] btb_tgt;
  logic [WORD_SIZE-1:0] next_pc;

  assign opcode   = fif.instruction[15:12];
  assign is_jump  = (opcode == OP_JMP) || (opcode == OP_JAL);
  // Jumps stay inside the current 4K page.
  assign jump_tgt = {fif.PC[15:12], fif.instruction[11:0]};
  assign pc_inc   = fif.PC + WORD_SIZE'(1);

  // Predecoded jumps win over the BTB: their target is exact.
  always_comb begin
    next_pc = pc_inc;
    if (is_jump)      next_pc = jump_tgt;
    else if (btb_hit) next_pc = btb_tgt;
  end

  assign fif.nextPC = next_pc;

`ifdef PCPRED_BTB_EN
  // ------------------------------------------------------------------
  // Direct-mapped BTB
  // ------------------------------------------------------------------
  localparam int ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int TAG_W   = WORD_SIZE - BTB_INDEX_BITS;

  logic [ENTRIES-1:0]   btb_valid;
  logic [TAG_W-1:0]     btb_tag    [ENTRIES];
  logic [WORD_SIZE-1:0] btb_target [ENTRIES];

  // PC of the previous fetch; a redirect this cycle refers to it.
  logic [WORD_SIZE-1:0] last_pc;

  // Lookup side
  logic [BTB_INDEX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]          pc_tag;

  assign pc_idx  = fif.PC[BTB_INDEX_BITS-1:0];
  assign pc_tag  = fif.PC[WORD_SIZE-1:BTB_INDEX_BITS];
  assign btb_hit = btb_valid[pc_idx] && (btb_tag[pc_idx] == pc_tag);
  assign btb_tgt = btb_target[pc_idx];

  // Training side
  logic [BTB_INDEX_BITS-1:0] lp_idx;
  logic [TAG_W-1:0]          lp_tag;
  logic [WORD_SIZE-1:0]      lp_inc;
  logic                      force_en;
  logic                      taken;
  logic                      train_wr;
  logic                      train_clr;

  assign lp_idx   = last_pc[BTB_INDEX_BITS-1:0];
  assign lp_tag   = last_pc[WORD_SIZE-1:BTB_INDEX_BITS];
  assign lp_inc   = last_pc + WORD_SIZE'(1);
  // Unknown redirect strobe behaves as "no redirect": an X condition in
  // the if below falls to the not-taken path.
  assign force_en = (fif.forcePC == 1'b1);
  // A redirect to the fall-through address means the fetch was not taken.
  assign taken    = (fif.forcePCdata != lp_inc);
  assign train_wr = force_en && taken;
  // Only drop the entry if it actually belongs to last_pc; an aliasing
  // entry from another page stays.
  assign train_clr = force_en && !taken && btb_valid[lp_idx] &&
                     (btb_tag[lp_idx] == lp_tag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btb_valid <= '0;
      last_pc   <= '0;
    end else begin
      last_pc <= fif.PC;
      if (train_wr)       btb_valid[lp_idx] <= 1'b1;
      else if (train_clr) btb_valid[lp_idx] <= 1'b0;
    end
  end

  // Tag/target need no reset (guarded by valid); still gated by reset_n so
  // edges during reset leave the arrays untouched.
  always_ff @(posedge clk) begin
    if (reset_n && train_wr) begin
      btb_tag[lp_idx]    <= lp_tag;
      btb_target[lp_idx] <= fif.forcePCdata;
    end
  end

`else
  // ------------------------------------------------------------------
  // No BTB: redirect inputs and clock/reset have no effect.
  // ------------------------------------------------------------------
  assign btb_hit = 1'b0;
  assign btb_tgt = '0;

  logic                      unused_in;
  logic [BTB_INDEX_BITS-1:0] unused_idx;

  assign unused_in  = ^{clk, reset_n, fif.forcePC, fif.forcePCdata};
  assign unused_idx = fif.PC[BTB_INDEX_BITS-1:0];
`endif

endmodule

// File: tb/tb_pc_next_predictor.sv
module tb_pc_next_predictor;

  logic clk;
  logic reset_n;

  pc_next_predictor_if #(.WORD_SIZE(16)) fif();

  pc_next_predictor #(
    .WORD_SIZE     (16),
    .BTB_INDEX_BITS(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .fif    (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Picks the expected value according to the build.
  function automatic logic [15:0] eb(input logic [15:0] with_btb,
                                     input logic [15:0] no_btb);
`ifdef PCPRED_BTB_EN
    eb = with_btb;
`else
    eb = no_btb;
`endif
  endfunction

  // Monitor: nextPC is always presented; compare on the falling edge
  // whenever the stimulus has queued an expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if (fif.nextPC !== e.exp) begin
        n_miss++;
        $display("FAIL %s: nextPC=%h expected %h (PC=%h instr=%h)",
                 e.name, fif.nextPC, e.exp, fif.PC, fif.instruction);
      end
    end
  end

  // One fetch cycle: drive just after the rising edge, queue expectation.
  task automatic drive(input logic [15:0] pc, input logic [15:0] instr,
                       input logic fpc, input logic [15:0] fdata,
                       input logic rst_n, input string name,
                       input logic [15:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    fif.PC          = pc;
    fif.instruction = instr;
    fif.forcePC     = fpc;
    fif.forcePCdata = fdata;
    reset_n         = rst_n;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    fif.PC          = '0;
    fif.instruction = '0;
    fif.forcePC     = 1'b0;
    fif.forcePCdata = '0;

    // Reset behaviour; redirect during reset must not train.
    drive(16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, "rst_inc",      16'h0011);
    drive(16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, "rst_inc2",     16'h0041);
    drive(16'h0080, 16'h0000, 1'b1, 16'h0090, 1'b0, "rst_force",    16'h0081);
    drive(16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b1, "rst_release",  16'h0041);
    drive(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, "no_rst_train", 16'h0001);
    drive(16'h0080, 16'h0000, 1'b0, 16'h0000, 1'b1, "no_rst_train2",16'h0081);

    // Sequential and wrap
    drive(16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b1, "seq",          16'h0011);
    drive(16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, "wrap",         16'h0000);

    // Predecode: opcodes 9/10 jump, 8/11 do not
    drive(16'h3004, 16'h9123, 1'b0, 16'h0000, 1'b1, "jmp",          16'h3123);
    drive(16'h3004, 16'hA0FF, 1'b0, 16'h0000, 1'b1, "jal",          16'h30FF);
    drive(16'h3004, 16'h8123, 1'b0, 16'h0000, 1'b1, "op8_nojump",   16'h3005);
    drive(16'h3004, 16'hB123, 1'b0, 16'h0000, 1'b1, "op11_nojump",  16'h3005);
    drive(16'hFFF0, 16'h9ABC, 1'b0, 16'h0000, 1'b1, "jmp_page",     16'hFABC);

    // Train taken 0x0020 -> 0x0050; lookup during the write sees old state
    drive(16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, "pre_train",    16'h0021);
    drive(16'h0020, 16'h0000, 1'b1, 16'h0050, 1'b1, "same_cyc_wr",  16'h0021);
    drive(16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, "taken_hit",    eb(16'h0050, 16'h0021));
    drive(16'h0020, 16'h9123, 1'b0, 16'h0000, 1'b1, "jmp_over_btb", 16'h0123);

    // Not-taken redirect clears the matching entry
    drive(16'h0021, 16'h0000, 1'b1, 16'h0021, 1'b1, "nt_cycle",     16'h0022);
    drive(16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, "nt_cleared",   16'h0021);

    // Retrain, then alias checks
    drive(16'h0050, 16'h0000, 1'b1, 16'h0050, 1'b1, "retrain",      16'h0051);
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "alias_miss",   16'h0121);
    // Not-taken for 0x0120 must not clear 0x0020's entry (tag differs)
    drive(16'h0121, 16'h0000, 1'b1, 16'h0121, 1'b1, "nt_alias_cyc", 16'h0122);
    drive(16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, "nt_alias_keep",eb(16'h0050, 16'h0021));
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "alias_pre",    16'h0121);
    drive(16'h0300, 16'h0000, 1'b1, 16'h0300, 1'b1, "alias_train",  16'h0301);
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "alias_hit",    eb(16'h0300, 16'h0121));
    drive(16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b1, "alias_evict",  16'h0021);
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "pre_async",    eb(16'h0300, 16'h0121));

    // Async reset mid-cycle: trained entry disappears immediately
    begin
      exp_t e;
      @(posedge clk);
      #1;
      fif.PC          = 16'h0120;
      fif.instruction = 16'h0000;
      fif.forcePC     = 1'b0;
      #1;
      reset_n = 1'b0;
      e.name = "async_rst";
      e.exp  = 16'h0121;
      sb.push_back(e);
    end
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "async_release",16'h0121);
    drive(16'h0120, 16'h0000, 1'b0, 16'h0000, 1'b1, "after_release",16'h0121);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
